// File: rtl/pkg_irrigacao.sv
// Shared types and codes for the reservoir pump controller.
package pkg_irrigacao;

   typedef enum logic [1:0] {
      DESLIGADA = 2'd0,
      LIGADA    = 2'd1,
      ERRO      = 2'd2
   } estado_t;

   localparam logic [1:0] VAZIO = 2'b00;
   localparam logic [1:0] BAIXO = 2'b01;
   localparam logic [1:0] MEDIO = 2'b10;
   localparam logic [1:0] ALTO  = 2'b11;

   localparam logic [1:0] ERRO_NENHUM     = 2'b00;
   localparam logic [1:0] ERRO_INCOERENTE = 2'b01;
   localparam logic [1:0] ERRO_TIMEOUT    = 2'b10;

   // Level code from filtered floats, evaluated bottom-up.
   function automatic logic [1:0] decodifica_nivel(input logic a, input logic m, input logic b);
      logic [1:0] cod;
      if (!b)      cod = VAZIO;
      else if (!m) cod = BAIXO;
      else if (!a) cod = MEDIO;
      else         cod = ALTO;
      return cod;
   endfunction

endpackage

// File: rtl/controle_bomba_nivel_debounce_sensor.sv
// Float sensor debouncer with a sticky "qualified" flag.
module debounce_sensor #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filt,
   output logic qualified
);

   localparam int W = $clog2(DEB_CYCLES) + 1;
   localparam logic [W-1:0] LIMITE = W'(DEB_CYCLES - 1);

   logic [W-1:0] cnt_dif;
   logic [W-1:0] cnt_est;

   // Disagreement counter accepts a change; agreement counter qualifies a steady sensor.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt      <= 1'b0;
         qualified <= 1'b0;
         cnt_dif   <= '0;
         cnt_est   <= '0;
      end else if (raw != filt) begin
         cnt_est <= '0;
         if (cnt_dif == LIMITE) begin
            filt      <= raw;
            cnt_dif   <= '0;
            qualified <= 1'b1;
         end else begin
            cnt_dif <= cnt_dif + 1'b1;
         end
      end else begin
         cnt_dif <= '0;
         if (cnt_est == LIMITE) qualified <= 1'b1;
         else                   cnt_est   <= cnt_est + 1'b1;
      end
   end

endmodule

// File: rtl/controle_bomba_nivel.sv
// Reservoir pump sequencer: debounced floats, coherence check, pump FSM with timers.
//
// state     | meaning
// DESLIGADA | pump off, waiting for low level and off-time
// LIGADA    | pump on, filling towards the high float
// ERRO      | pump locked off until acknowledged with coherent sensors
module controle_bomba_nivel
   import pkg_irrigacao::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int MIN_ON     = 16,
   parameter int MIN_OFF    = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sensor_a,
   input  logic       sensor_m,
   input  logic       sensor_b,
   input  logic       enable,
   input  logic       limpa_erro,
   output logic       bomba,
   output logic [1:0] nivel,
   output logic       nivel_valido,
   output logic       erro,
   output logic [1:0] erro_cod
);

   localparam int ON_W  = $clog2(TIMEOUT) + 1;
   localparam int OFF_W = $clog2(MIN_OFF) + 1;
   localparam logic [ON_W-1:0]  ON_MIN  = ON_W'(MIN_ON);
   localparam logic [ON_W-1:0]  ON_MAX  = ON_W'(TIMEOUT);
   // Timeout fires on the edge where the on-timer reaches TIMEOUT.
   localparam logic [ON_W-1:0]  ON_LIM  = ON_W'(TIMEOUT - 1);
   localparam logic [OFF_W-1:0] OFF_MIN = OFF_W'(MIN_OFF);

   logic fa, fm, fb;
   logic qa, qm, qb;
   logic incoerente;

   estado_t          estado, estado_prox;
   logic [1:0]       cod_prox;
   logic [ON_W-1:0]  on_timer;
   logic [OFF_W-1:0] off_timer;

   debounce_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (.clk(clk), .rst(rst), .raw(sensor_a), .filt(fa), .qualified(qa));
   debounce_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_deb_m (.clk(clk), .rst(rst), .raw(sensor_m), .filt(fm), .qualified(qm));
   debounce_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (.clk(clk), .rst(rst), .raw(sensor_b), .filt(fb), .qualified(qb));

   // Qualified flags are sticky, so their AND holds until reset.
   assign nivel_valido = qa & qm & qb;
   assign incoerente   = nivel_valido & ((fa & ~fm) | (fm & ~fb));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) estado <= DESLIGADA;
      else     estado <= estado_prox;
   end

   // Next state and error cause; incoherence outranks every other transition.
   always_comb begin
      estado_prox = estado;
      cod_prox    = erro_cod;
      case (estado)
         DESLIGADA: begin
            if (incoerente) begin
               estado_prox = ERRO;
               cod_prox    = ERRO_INCOERENTE;
            end else if (enable && nivel_valido && !fb && off_timer >= OFF_MIN) begin
               estado_prox = LIGADA;
            end
         end
         LIGADA: begin
            if (incoerente) begin
               estado_prox = ERRO;
               cod_prox    = ERRO_INCOERENTE;
            end else if (!enable) begin
               estado_prox = DESLIGADA;
            end else if (fa && on_timer >= ON_MIN) begin
               estado_prox = DESLIGADA;
            end else if (!fa && on_timer >= ON_LIM) begin
               estado_prox = ERRO;
               cod_prox    = ERRO_TIMEOUT;
            end
         end
         ERRO: begin
            if (limpa_erro && !incoerente) begin
               estado_prox = DESLIGADA;
               cod_prox    = ERRO_NENHUM;
            end
         end
         default: begin
            estado_prox = DESLIGADA;
            cod_prox    = ERRO_NENHUM;
         end
      endcase
   end

   // Registered outputs follow the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         bomba    <= 1'b0;
         erro     <= 1'b0;
         erro_cod <= ERRO_NENHUM;
         nivel    <= VAZIO;
      end else begin
         bomba    <= (estado_prox == LIGADA);
         erro     <= (estado_prox == ERRO);
         erro_cod <= cod_prox;
         nivel    <= decodifica_nivel(fa, fm, fb);
      end
   end

   // On/off timers: cleared on state entry, saturating; off-timer starts satisfied.
   always_ff @(posedge clk) begin
      if (rst) begin
         on_timer  <= '0;
         off_timer <= OFF_MIN;
      end else begin
         if (estado_prox == LIGADA && estado != LIGADA)
            on_timer <= '0;
         else if (estado == LIGADA && on_timer < ON_MAX)
            on_timer <= on_timer + 1'b1;

         if (estado_prox != LIGADA && estado_prox != estado)
            off_timer <= '0;
         else if (estado != LIGADA && off_timer < OFF_MIN)
            off_timer <= off_timer + 1'b1;
      end
   end

endmodule

// File: tb/tb_controle_bomba_nivel.sv
// Directed bench for the reservoir pump controller.
module tb_controle_bomba_nivel;

   logic       clk = 1'b0;
   logic       rst;
   logic       sensor_a, sensor_m, sensor_b, enable, limpa_erro;
   logic       bomba;
   logic [1:0] nivel;
   logic       nivel_valido;
   logic       erro;
   logic [1:0] erro_cod;

   int n_checks = 0;
   int n_pass   = 0;

   controle_bomba_nivel #(
      .DEB_CYCLES(4), .MIN_ON(16), .MIN_OFF(16), .TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst),
      .sensor_a(sensor_a), .sensor_m(sensor_m), .sensor_b(sensor_b),
      .enable(enable), .limpa_erro(limpa_erro),
      .bomba(bomba), .nivel(nivel), .nivel_valido(nivel_valido),
      .erro(erro), .erro_cod(erro_cod)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       a, m, b, en, lim;
      int         hold;
      logic       e_bomba;
      logic [1:0] e_nivel;
      logic       cn;
      logic       e_val;
      logic       e_erro;
      logic [1:0] e_cod;
   } vetor_t;

   vetor_t tab [23];

   task automatic chk1(input string nome, input logic atual, input logic esperado);
      n_checks++;
      if (atual === esperado) n_pass++;
      else $display("FAIL %s: got %b expected %b", nome, atual, esperado);
   endtask

   task automatic chk2(input string nome, input logic [1:0] atual, input logic [1:0] esperado);
      n_checks++;
      if (atual === esperado) n_pass++;
      else $display("FAIL %s: got %b expected %b", nome, atual, esperado);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_in(input logic a, input logic m, input logic b, input logic en, input logic lim);
      sensor_a   = a;
      sensor_m   = m;
      sensor_b   = b;
      enable     = en;
      limpa_erro = lim;
   endtask

   task automatic espera_bomba(input string nome, input int limite);
      int k = 0;
      while (bomba !== 1'b1 && k < limite) begin
         tick(1);
         k++;
      end
      chk1(nome, bomba, 1'b1);
   endtask

   initial begin
      // a m b en lim hold | bomba nivel cn valido erro cod
      tab[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 3, 1'b0,2'b00,1'b1, 1'b0,1'b0,2'b00};
      tab[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1, 1'b0,2'b00,1'b1, 1'b1,1'b0,2'b00};
      tab[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1, 1'b1,2'b00,1'b1, 1'b1,1'b0,2'b00};
      tab[3]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 3, 1'b1,2'b00,1'b1, 1'b1,1'b0,2'b00};
      tab[4]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1, 1'b1,2'b00,1'b1, 1'b1,1'b0,2'b00};
      tab[5]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1, 1'b1,2'b01,1'b1, 1'b1,1'b0,2'b00};
      tab[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 5, 1'b1,2'b01,1'b1, 1'b1,1'b0,2'b00};
      tab[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 4, 1'b1,2'b01,1'b1, 1'b1,1'b0,2'b00};
      tab[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1, 1'b1,2'b10,1'b1, 1'b1,1'b0,2'b00};
      tab[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 5, 1'b1,2'b10,1'b1, 1'b1,1'b0,2'b00};
      tab[10] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 4, 1'b1,2'b10,1'b1, 1'b1,1'b0,2'b00};
      tab[11] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1, 1'b0,2'b11,1'b1, 1'b1,1'b0,2'b00};
      tab[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,16, 1'b0,2'b00,1'b1, 1'b1,1'b0,2'b00};
      tab[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1, 1'b1,2'b00,1'b1, 1'b1,1'b0,2'b00};
      tab[14] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 3, 1'b1,2'b00,1'b1, 1'b1,1'b0,2'b00};
      tab[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 3, 1'b1,2'b00,1'b1, 1'b1,1'b0,2'b00};
      tab[16] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 4, 1'b1,2'b00,1'b1, 1'b1,1'b0,2'b00};
      tab[17] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 1, 1'b0,2'b00,1'b0, 1'b1,1'b1,2'b01};
      tab[18] = '{1'b1,1'b0,1'b1,1'b1,1'b1, 1, 1'b0,2'b00,1'b0, 1'b1,1'b1,2'b01};
      tab[19] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 4, 1'b0,2'b00,1'b0, 1'b1,1'b1,2'b01};
      tab[20] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1, 1'b0,2'b11,1'b1, 1'b1,1'b1,2'b01};
      tab[21] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1, 1'b0,2'b11,1'b1, 1'b1,1'b0,2'b00};
      tab[22] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 2, 1'b0,2'b11,1'b1, 1'b1,1'b0,2'b00};

      // Reset values
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(2);
      chk1("rst bomba", bomba, 1'b0);
      chk2("rst nivel", nivel, 2'b00);
      chk1("rst valido", nivel_valido, 1'b0);
      chk1("rst erro", erro, 1'b0);
      chk2("rst cod", erro_cod, 2'b00);
      rst = 1'b0;

      // Power-up, fill, MIN_OFF restart, glitch, incoherence and acknowledge
      for (int i = 0; i < 23; i++) begin
         set_in(tab[i].a, tab[i].m, tab[i].b, tab[i].en, tab[i].lim);
         tick(tab[i].hold);
         chk1($sformatf("v%0d bomba", i), bomba, tab[i].e_bomba);
         if (tab[i].cn) chk2($sformatf("v%0d nivel", i), nivel, tab[i].e_nivel);
         chk1($sformatf("v%0d valido", i), nivel_valido, tab[i].e_val);
         chk1($sformatf("v%0d erro", i), erro, tab[i].e_erro);
         chk2($sformatf("v%0d cod", i), erro_cod, tab[i].e_cod);
      end

      // Fill timeout: only B present, pump on for 64 cycles then ERRO
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1);
      rst = 1'b0;
      tick(5);
      chk1("to pump on", bomba, 1'b1);
      sensor_b = 1'b1;
      tick(63);
      chk1("to bomba before", bomba, 1'b1);
      chk1("to erro before", erro, 1'b0);
      tick(1);
      chk1("to erro", erro, 1'b1);
      chk2("to cod", erro_cod, 2'b10);
      chk1("to bomba", bomba, 1'b0);
      chk2("to nivel", nivel, 2'b01);

      // Enable drop ignores MIN_ON
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1);
      rst = 1'b0;
      tick(5);
      chk1("en pump on", bomba, 1'b1);
      tick(5);
      chk1("en still on", bomba, 1'b1);
      enable = 1'b0;
      tick(1);
      chk1("en drop bomba", bomba, 1'b0);
      chk1("en drop erro", erro, 1'b0);

      // Reset while pumping
      enable = 1'b1;
      espera_bomba("restart wait", 40);
      rst = 1'b1;
      tick(1);
      chk1("mid rst bomba", bomba, 1'b0);
      chk2("mid rst nivel", nivel, 2'b00);
      chk1("mid rst valido", nivel_valido, 1'b0);
      chk1("mid rst erro", erro, 1'b0);
      chk2("mid rst cod", erro_cod, 2'b00);
      rst = 1'b0;
      tick(3);
      chk1("requal early", nivel_valido, 1'b0);
      tick(1);
      chk1("requal", nivel_valido, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/controle_bomba_nivel.md
Name: controle_bomba_nivel

Overview:
- Sequences the irrigation reservoir pump from the three float sensors: high (A), medium (M) and low (B).
- Debounces the sensors, checks that their combination is coherent, and runs a pump FSM with hysteresis, minimum on/off times and a fill timeout.
- Outputs a registered 2-bit level code for the level-display decoder and an error code for the alarm indicator.

Parameters:
- DEB_CYCLES, 4: consecutive identical raw samples needed to accept a sensor change (>=1).
- MIN_ON, 16: minimum cycles the pump stays on before a level-based stop.
- MIN_OFF, 16: minimum cycles the pump stays off before a restart.
- TIMEOUT, 1024: maximum cycles in LIGADA without reaching high level.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sensor_a  in  1  raw high-level float, 1 = water present
- sensor_m  in  1  raw medium-level float
- sensor_b  in  1  raw low-level float
- enable  in  1  operator enable for automatic filling
- limpa_erro  in  1  single-cycle error acknowledge
- bomba  out  1  pump drive, 1 = on
- nivel  out  2  00 empty, 01 low, 10 medium, 11 high
- nivel_valido  out  1  all three sensors qualified since reset
- erro  out  1  FSM in ERRO
- erro_cod  out  2  00 none, 01 incoherent sensors, 10 fill timeout

Behaviour:
- Reset values: bomba=0, nivel=00, nivel_valido=0, erro=0, erro_cod=00.
- Reset state: FSM=DESLIGADA, filtered sensors=0, all counters=0, off-timer satisfied.
- Debounce, per sensor:
  - Counter increments while raw != filtered and clears when raw == filtered.
  - On the edge where the counter reaches DEB_CYCLES, filtered takes raw and the counter clears.
  - If raw equals filtered for DEB_CYCLES cycles, the sensor becomes qualified; a sensor is also qualified when filtered updates.
  - nivel_valido rises once all three sensors are qualified and stays high until reset.
- Level decode from filtered values, registered with 1 cycle latency:
  - B=0 -> 00; B&~M -> 01; M&~A -> 10; A -> 11.
- Incoherent combination: A&~M, or M&~B. Only evaluated while nivel_valido=1.
- FSM states: DESLIGADA, LIGADA, ERRO.
- DESLIGADA -> LIGADA when enable & nivel_valido & filtered B=0 & off-timer >= MIN_OFF.
- LIGADA -> DESLIGADA when:
  - enable=0 (immediate, ignores MIN_ON), or
  - filtered A=1 and on-timer >= MIN_ON.
- LIGADA -> ERRO with erro_cod=10 when on-timer reaches TIMEOUT while A=0.
- Any state -> ERRO with erro_cod=01 on incoherent sensors. Incoherence has priority over timeout in the same cycle.
- ERRO -> DESLIGADA on limpa_erro=1 with a coherent combination in that cycle. Otherwise stay in ERRO; erro_cod holds the first cause.
- Timers:
  - On-timer clears on entering LIGADA and saturates at TIMEOUT.
  - Off-timer clears on entering DESLIGADA or ERRO and saturates at MIN_OFF.
- Register widths are sized by $clog2 of their parameter + 1.
- Outputs:
  - bomba is registered and equals (state==LIGADA); it is never 1 in ERRO.
  - erro is registered and equals (state==ERRO).
- rst during LIGADA forces bomba=0 on the same edge; debouncing restarts from zero.
- limpa_erro outside ERRO is ignored. enable toggling in ERRO has no effect.

Decomposition:
- Package pkg_irrigacao: state encoding, nivel codes (VAZIO, BAIXO, MEDIO, ALTO) and erro_cod constants.
- One sub-module, debounce_sensor (parameter DEB_CYCLES; ports clk, rst, raw, filt, qualified), instantiated three times.
- Level decode, coherence check and FSM stay in the top module.

Test Plan:
Bench parameters: DEB_CYCLES=4, MIN_ON=16, MIN_OFF=16, TIMEOUT=64.
1. Power-up empty: rst, then A=M=B=0, enable=1 -> nivel_valido after 4 cycles; bomba=1 on the next cycle; nivel=00.
2. Fill sequence: raise B, then M, then A, each stable 10 cycles, starting after pump-on -> nivel steps 01, 10, 11, each 4-5 cycles after the raw edge. bomba=0 once A is filtered and on-timer >= 16. No restart until B=0 and MIN_OFF has elapsed.
3. Glitch rejection: with A filtered 0, pulse sensor_a high for 3 cycles -> filtered A unchanged, nivel unchanged, bomba unchanged.
4. Incoherent sensors: A=1, M=0, B=1 held for 4 cycles while pumping -> erro=1, erro_cod=01, bomba=0. limpa_erro while still incoherent -> stays in ERRO. Fix sensors, then limpa_erro -> DESLIGADA.
5. Timeout: pump on, sensors stuck at B=1 only -> after 64 cycles in LIGADA: erro=1, erro_cod=10, bomba=0.
6. Enable drop and reset mid-fill: enable=0 at on-timer=5 -> bomba=0 on the next edge. Separately, rst while bomba=1 -> all outputs at reset values on the same edge; nivel_valido=0 until re-qualified.
